// File: rtl/shim_integ_thresh_monitor_if.sv
// Bundle of synchronized config, sample stream and status for the shim integrating threshold monitor.
// Optional last_sum status appears only when SHIM_INTEG_SUM_OUT_EN is defined.
interface shim_integ_thresh_monitor_if #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int THRESH_WIDTH = 15,
  parameter int WINDOW_WIDTH = 32
);
  localparam int ACC_WIDTH = SAMPLE_WIDTH - 1 + WINDOW_WIDTH;

  logic                    integ_en;
  logic [WINDOW_WIDTH-1:0] integ_window;
  logic [THRESH_WIDTH-1:0] integ_thresh_avg;
  logic [SAMPLE_WIDTH-1:0] sample;
  logic                    sample_valid;
  logic                    window_done;
  logic                    over_thresh;
  logic                    cfg_err;
  logic                    running;
`ifdef SHIM_INTEG_SUM_OUT_EN
  logic [ACC_WIDTH-1:0]    last_sum;
`endif

  // Handshake: sample_valid qualifies sample for exactly one spi_clk cycle; there is no
  // ready/backpressure, the monitor accepts (or deliberately ignores) every valid beat.
  modport master (
    output integ_en, integ_window, integ_thresh_avg, sample, sample_valid,
`ifdef SHIM_INTEG_SUM_OUT_EN
    input  last_sum,
`endif
    input  window_done, over_thresh, cfg_err, running
  );

  modport slave (
    input  integ_en, integ_window, integ_thresh_avg, sample, sample_valid,
`ifdef SHIM_INTEG_SUM_OUT_EN
    output last_sum,
`endif
    output window_done, over_thresh, cfg_err, running
  );
endinterface

// File: rtl/shim_integ_thresh_monitor.sv
// Windowed |sample| integrator with sticky over-threshold fault for the shim amplifier.
// Define SHIM_INTEG_SUM_OUT_EN to expose the last evaluated window sum on bus.last_sum.
module shim_integ_thresh_monitor #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int THRESH_WIDTH = 15,
  parameter int WINDOW_WIDTH = 32,
  localparam int ACC_WIDTH   = SAMPLE_WIDTH - 1 + WINDOW_WIDTH
) (
  input  logic                        spi_clk,
  input  logic                        spi_reset,
  shim_integ_thresh_monitor_if.slave  bus,
  output logic [1:0]                  dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CMP   = 2'd2,
    FAULT = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [ACC_WIDTH-1:0]      acc;
  logic [WINDOW_WIDTH-1:0]   cnt;
  logic [WINDOW_WIDTH-1:0]   shadow_window;
  logic [ACC_WIDTH-1:0]      limit_q;
  logic                      over_q;

  logic [SAMPLE_WIDTH-1:0]   neg_sample;
  logic [SAMPLE_WIDTH-2:0]   mag;
  logic [ACC_WIDTH-1:0]      mag_ext;
  logic [ACC_WIDTH-1:0]      acc_sum;
  logic [WINDOW_WIDTH-1:0]   cnt_inc;
  logic [ACC_WIDTH-1:0]      limit_full;
  logic                      last_valid;
  logic                      over_now;

  // Negating the most negative code wraps back to itself; clamp it to the largest magnitude.
  assign neg_sample = -bus.sample;
  always_comb begin
    mag = bus.sample[SAMPLE_WIDTH-2:0];
    if (bus.sample[SAMPLE_WIDTH-1]) begin
      if (neg_sample[SAMPLE_WIDTH-1]) mag = {(SAMPLE_WIDTH-1){1'b1}};
      else                            mag = neg_sample[SAMPLE_WIDTH-2:0];
    end
  end

  assign mag_ext    = ACC_WIDTH'(mag);
  assign acc_sum    = acc + mag_ext;
  assign cnt_inc    = cnt + WINDOW_WIDTH'(1);
  assign last_valid = bus.sample_valid && (cnt_inc == shadow_window);
  assign limit_full = ACC_WIDTH'(bus.integ_thresh_avg) * ACC_WIDTH'(bus.integ_window);

  // The fault must be visible in the same cycle as window_done, so it is decoded from acc in CMP.
  assign over_now = (state == CMP) && bus.integ_en && (acc > limit_q);

  // State register
  always_ff @(posedge spi_clk or posedge spi_reset) begin
    if (spi_reset) state <= IDLE;
    else           state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (!bus.integ_en) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:  if (bus.integ_window != '0) state_nxt = RUN;
        RUN:   if (last_valid) state_nxt = CMP;
        CMP: begin
          if (over_now)                                           state_nxt = FAULT;
          else if (bus.sample_valid && shadow_window == WINDOW_WIDTH'(1)) state_nxt = CMP;
          else                                                    state_nxt = RUN;
        end
        FAULT: state_nxt = FAULT;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Outputs
  always_comb begin
    bus.window_done = 1'b0;
    bus.running     = 1'b0;
    bus.cfg_err     = 1'b0;
    bus.over_thresh = over_q | over_now;
    dbg_state       = state;
    case (state)
      IDLE:    bus.cfg_err = bus.integ_en && (bus.integ_window == '0);
      RUN:     bus.running = 1'b1;
      CMP: begin
        bus.running     = 1'b1;
        bus.window_done = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef SHIM_INTEG_SUM_OUT_EN
  logic [ACC_WIDTH-1:0] last_sum_q;
  assign bus.last_sum = last_sum_q;
`endif

  // Datapath: accumulator, sample counter, shadow config, sticky fault
  always_ff @(posedge spi_clk or posedge spi_reset) begin
    if (spi_reset) begin
      acc           <= '0;
      cnt           <= '0;
      shadow_window <= '0;
      limit_q       <= '0;
      over_q        <= 1'b0;
`ifdef SHIM_INTEG_SUM_OUT_EN
      last_sum_q    <= '0;
`endif
    end else if (!bus.integ_en) begin
      acc        <= '0;
      cnt        <= '0;
      over_q     <= 1'b0;
`ifdef SHIM_INTEG_SUM_OUT_EN
      last_sum_q <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          acc           <= '0;
          cnt           <= '0;
          shadow_window <= bus.integ_window;
          limit_q       <= limit_full;
        end
        RUN: begin
          if (bus.sample_valid) begin
            acc <= acc_sum;
            cnt <= last_valid ? '0 : cnt_inc;
          end
        end
        CMP: begin
`ifdef SHIM_INTEG_SUM_OUT_EN
          last_sum_q <= acc;
`endif
          if (over_now) over_q <= 1'b1;
          // A beat arriving during evaluation opens the next window.
          if (bus.sample_valid) begin
            acc <= mag_ext;
            cnt <= WINDOW_WIDTH'(1);
          end else begin
            acc <= '0;
            cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
